color_sequencer: RTL and testbench

COLOR_SEQUENCER -- requirements
Module: color_sequencer

---
 rtl/color_pkg.sv | 31 +++
 rtl/frame_edge_detect.sv | 29 ++
 rtl/color_sequencer.sv | 94 +++++++++
 tb/tb_color_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour sequencer: mode encodings, colour indices
// in RGB display switch order, and the manual-selection priority helper.
package color_pkg;

  localparam int NUM_COLORS = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10
  } mode_t;

  localparam logic [IDX_W-1:0] BLACK   = 3'd0;
  localparam logic [IDX_W-1:0] BLUE    = 3'd1;
  localparam logic [IDX_W-1:0] GREEN   = 3'd2;
  localparam logic [IDX_W-1:0] CYAN    = 3'd3;
  localparam logic [IDX_W-1:0] RED     = 3'd4;
  localparam logic [IDX_W-1:0] MAGENTA = 3'd5;
  localparam logic [IDX_W-1:0] YELLOW  = 3'd6;
  localparam logic [IDX_W-1:0] WHITE   = 3'd7;

  // Lowest set switch wins; no switch set selects black.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_COLORS-1:0] bits);
    lowest_set = BLACK;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (bits[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Two-flop synchronizer for the VGA visible flag plus falling-edge detection.
// fall is the pre-register strobe; tick is its registered copy (the frame pulse).
module frame_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic fall,
  output logic tick
);

  logic [1:0] sync_p0;
  logic       last_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      last_p1 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[0], level};
      last_p1 <= sync_p0[1];
      tick    <= fall;
    end
  end

  // last_p1 cleared in reset, so a fresh 1 -> 0 is needed after release
  assign fall = last_p1 & ~sync_p0[1];

endmodule

// File: rtl/color_sequencer.sv
// Frame-synchronous colour selector: manual pick from switches or timed
// auto-cycle through all eight colours, updating only at frame boundaries.
module color_sequencer
  import color_pkg::*;
#(
  parameter int HOLD_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_COLORS-1:0] switch,
  input  logic                  auto_en,
  input  logic                  v_visable,
  output logic [NUM_COLORS-1:0] sel,
  output logic [IDX_W-1:0]      idx,
  output logic [1:0]            mode,
  output logic                  frame_tick
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  logic [NUM_COLORS-1:0] switch_p0, switch_p1;
  logic                  auto_p0, auto_p1;
  logic                  fall;
  logic [IDX_W-1:0]      manual_idx;
  mode_t                 state, state_n;
  logic [IDX_W-1:0]      idx_n;
  logic [7:0]            hold_cnt, hold_cnt_n;

  frame_edge_detect u_frame_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (v_visable),
    .fall  (fall),
    .tick  (frame_tick)
  );

  assign manual_idx = lowest_set(switch_p1);

  // State register: synchronizers, FSM state and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      switch_p0 <= '0;
      switch_p1 <= '0;
      auto_p0   <= 1'b0;
      auto_p1   <= 1'b0;
      state     <= IDLE;
      idx       <= BLACK;
      hold_cnt  <= '0;
      sel       <= NUM_COLORS'(1);
    end else begin
      switch_p0 <= switch;
      switch_p1 <= switch_p0;
      auto_p0   <= auto_en;
      auto_p1   <= auto_p0;
      state     <= state_n;
      idx       <= idx_n;
      hold_cnt  <= hold_cnt_n;
      sel       <= NUM_COLORS'(1) << idx_n;
    end
  end

  // Next state: only a frame boundary may move the FSM
  always_comb begin
    state_n = state;
    if (fall) begin
      case (state)
        IDLE, MANUAL, AUTO: state_n = auto_p1 ? AUTO : MANUAL;
        default:            state_n = IDLE;
      endcase
    end
  end

  // Index and hold counter; a mode change takes priority over an auto advance
  always_comb begin
    idx_n      = idx;
    hold_cnt_n = hold_cnt;
    if (fall) begin
      if (state_n == MANUAL) begin
        idx_n      = manual_idx;
        hold_cnt_n = '0;
      end else if (state != AUTO) begin
        hold_cnt_n = '0;
      end else if (hold_cnt >= HOLD_LAST) begin
        idx_n      = (idx == WHITE) ? BLACK : idx + IDX_W'(1);
        hold_cnt_n = '0;
      end else begin
        hold_cnt_n = hold_cnt + 8'd1;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_color_sequencer.sv
// Bench for color_sequencer: table-driven frame sequence, corner-case sequences
// and randomized frames against a frame-level behavioural model.
module tb_color_sequencer;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] switch = '0;
  logic       auto_en = 1'b0;
  logic       v_visable = 1'b0;
  logic [7:0] sel;
  logic [2:0] idx;
  logic [1:0] mode;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  bit started = 1'b0;

  int m_mode, m_idx, m_cnt;

  typedef struct {
    logic [7:0] sw;
    logic       a;
    logic [2:0] e_idx;
    logic [1:0] e_mode;
  } vec_t;

  vec_t tbl[14];

  color_sequencer #(.HOLD_FRAMES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .switch     (switch),
    .auto_en    (auto_en),
    .v_visable  (v_visable),
    .sel        (sel),
    .idx        (idx),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_tick === 1'b1) tick_cnt++;

  // sel must always be one-hot and match idx; mode 11 must never appear
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (sel !== (8'h01 << idx) || mode === 2'b11) begin
        errors++;
        $display("FAIL onehot: sel=%0h idx=%0d mode=%0d required sel=1<<idx", sel, idx, mode);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    started = 1'b1;
    chk("rst_sel", sel, 8'h01);
    chk("rst_idx", idx, 0);
    chk("rst_mode", mode, 0);
    chk("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    m_mode = 0; m_idx = 0; m_cnt = 0;
  endtask

  // One frame: inputs settle while visible, then a falling edge; outputs must
  // hold for two cycles and update together with frame_tick on the third.
  task automatic frame(input logic [7:0] sw, input logic a, input logic [2:0] e_idx,
                       input logic [1:0] e_mode, input string nm);
    logic [7:0] prev;
    switch = sw;
    auto_en = a;
    v_visable = 1'b1;
    repeat (5 + $urandom_range(0, 3)) step();
    prev = sel;
    v_visable = 1'b0;
    step();
    step();
    chk({nm, "_early_tick"}, frame_tick, 0);
    chk({nm, "_early_sel"}, sel, prev);
    step();
    chk({nm, "_tick"}, frame_tick, 1);
    chk({nm, "_idx"}, idx, e_idx);
    chk({nm, "_sel"}, sel, 8'h01 << e_idx);
    chk({nm, "_mode"}, mode, e_mode);
    step();
    chk({nm, "_tick_end"}, frame_tick, 0);
  endtask

  function automatic int lowest(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  // Frame-level model: counts frames spent on a colour in auto mode
  task automatic model_frame(input logic [7:0] sw, input logic a);
    if (!a) begin
      m_mode = 1; m_idx = lowest(sw); m_cnt = 0;
    end else if (m_mode != 2) begin
      m_mode = 2; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == HOLD) begin
        m_idx = (m_idx + 1) % 8;
        m_cnt = 0;
      end
    end
  endtask

  initial begin
    int t0;
    logic [7:0] s0;
    logic [7:0] rsw;
    logic ra;

    tbl[0]  = '{8'h14, 1'b0, 3'd2, 2'b01};
    tbl[1]  = '{8'h80, 1'b0, 3'd7, 2'b01};
    tbl[2]  = '{8'h40, 1'b0, 3'd6, 2'b01};
    tbl[3]  = '{8'h40, 1'b1, 3'd6, 2'b10};
    tbl[4]  = '{8'h40, 1'b1, 3'd6, 2'b10};
    tbl[5]  = '{8'h01, 1'b1, 3'd7, 2'b10};
    tbl[6]  = '{8'h01, 1'b1, 3'd7, 2'b10};
    tbl[7]  = '{8'h02, 1'b1, 3'd0, 2'b10};
    tbl[8]  = '{8'h02, 1'b1, 3'd0, 2'b10};
    tbl[9]  = '{8'h04, 1'b1, 3'd1, 2'b10};
    tbl[10] = '{8'h04, 1'b1, 3'd1, 2'b10};
    tbl[11] = '{8'h00, 1'b0, 3'd0, 2'b01};
    tbl[12] = '{8'h0C, 1'b0, 3'd2, 2'b01};
    tbl[13] = '{8'h03, 1'b1, 3'd2, 2'b10};

    step();
    do_reset();

    for (int i = 0; i < 14; i++)
      frame(tbl[i].sw, tbl[i].a, tbl[i].e_idx, tbl[i].e_mode, $sformatf("tbl%0d", i));

    // Switch change mid-frame must not reach the outputs
    frame(8'h14, 1'b0, 3'd2, 2'b01, "mid_a");
    switch = 8'h80;
    repeat (20) step();
    chk("mid_hold_sel", sel, 8'h04);
    chk("mid_hold_idx", idx, 2);
    frame(8'h80, 1'b0, 3'd7, 2'b01, "mid_b");

    // Reset in auto at idx 5 with an edge in flight
    frame(8'h20, 1'b0, 3'd5, 2'b01, "ar_man");
    frame(8'h20, 1'b1, 3'd5, 2'b10, "ar_auto");
    v_visable = 1'b1;
    repeat (5) step();
    v_visable = 1'b0;
    step();
    do_reset();
    t0 = tick_cnt;
    repeat (10) step();
    chk("ar_no_tick", tick_cnt - t0, 0);
    chk("ar_idle_mode", mode, 0);
    frame(8'h20, 1'b1, 3'd0, 2'b10, "ar_first");

    // Visible flag held high: nothing may change
    s0 = sel;
    t0 = tick_cnt;
    v_visable = 1'b1;
    repeat (10000) step();
    chk("hold_ticks", tick_cnt - t0, 0);
    chk("hold_sel", sel, s0);

    // Randomized frames against the model
    v_visable = 1'b0;
    repeat (3) step();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rsw = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rsw = 8'h00;
      ra = ($urandom_range(0, 2) != 0);
      model_frame(rsw, ra);
      frame(rsw, ra, 3'(m_idx), 2'(m_mode), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
